// File: rtl/flash_pkg.sv
// Shared definitions for the SPI configuration-flash word reader.
package flash_pkg;

    typedef enum logic [3:0] {
        S_WAKE,
        S_WGAP,
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE,
        S_GAP
    } state_t;

    localparam logic [7:0] CMD_WAKE     = 8'hAB;
    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_FASTREAD = 8'h0B;
    localparam int         ADDR_BITS    = 24;
    localparam int         DATA_BITS    = 16;

endpackage

// File: rtl/flash_spi_shift.sv
// Mode-0 SPI bit engine: two clk cycles per bit, sck low then high.
// MOSI is the MSB of the shift register; MISO enters at the LSB on the
// clk edge that ends the high phase. A load restarts the engine with a
// new word and bit count; it stops by itself when the count runs out.
module flash_spi_shift
    import flash_pkg::*;
#(
    parameter int W = ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 load,
    input  logic [W-1:0]         load_data,
    input  logic [5:0]           load_bits,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic                 last,
    output logic [DATA_BITS-1:0] rx_word
);

    logic         active;
    logic [5:0]   cnt;
    logic [W-1:0] sr;

    assign mosi    = sr[W-1];
    // High in the final cycle of the final bit; the caller may load here.
    assign last    = active & sck & (cnt == 6'd1);
    // Received word including the bit being sampled on this edge.
    assign rx_word = {sr[DATA_BITS-2:0], miso};

    // Phase toggle, sck generation and MSB-first shift/count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
            sck    <= 1'b0;
            cnt    <= '0;
            sr     <= '0;
        end else if (load) begin
            active <= 1'b1;
            sck    <= 1'b0;
            cnt    <= load_bits;
            sr     <= load_data;
        end else if (active) begin
            if (sck) begin
                sck <= 1'b0;
                sr  <= {sr[W-2:0], miso};
                cnt <= cnt - 6'd1;
                if (cnt == 6'd1)
                    active <= 1'b0;
            end else begin
                sck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_reader.sv
// SPI-flash word reader: wakes the flash from deep power-down after reset,
// then serves 16-bit reads through a ready/rd/ack handshake.
module flash_reader
    import flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD   = CMD_READ,
    parameter int         DUMMY_BITS = 0,
    parameter int         WAKE_WAIT  = 300
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ready,
    input  logic        rd,
    input  logic [21:0] addr,
    output logic [15:0] dout,
    output logic        ack,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_t                 state;
    logic [15:0]            wcnt;
    logic [ADDR_BITS-1:0]   baddr;
    logic                   sh_load;
    logic [ADDR_BITS-1:0]   sh_data;
    logic [5:0]             sh_bits;
    logic                   sh_last;
    logic [DATA_BITS-1:0]   sh_rx;

    flash_spi_shift #(.W(ADDR_BITS)) u_shift (
        .clk       (clk),
        .resetn    (resetn),
        .load      (sh_load),
        .load_data (sh_data),
        .load_bits (sh_bits),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .last      (sh_last),
        .rx_word   (sh_rx)
    );

    // Shifter (re)load at the start of each serial segment.
    always_comb begin
        sh_load = 1'b0;
        sh_data = '0;
        sh_bits = '0;
        case (state)
            S_WAKE:  if (spi_cs_n) begin
                         sh_load = 1'b1;
                         sh_data = {CMD_WAKE, 16'h0};
                         sh_bits = 6'd8;
                     end
            S_IDLE:  if (rd) begin
                         sh_load = 1'b1;
                         sh_data = {READ_CMD, 16'h0};
                         sh_bits = 6'd8;
                     end
            S_CMD:   if (sh_last) begin
                         sh_load = 1'b1;
                         sh_data = baddr;
                         sh_bits = 6'(ADDR_BITS);
                     end
            // Data and dummy segments shift in from a zeroed register so
            // MOSI stays low while the flash talks.
            S_ADDR:  if (sh_last) begin
                         sh_load = 1'b1;
                         sh_bits = (DUMMY_BITS > 0) ? 6'(DUMMY_BITS) : 6'(DATA_BITS);
                     end
            S_DUMMY: if (sh_last) begin
                         sh_load = 1'b1;
                         sh_bits = 6'(DATA_BITS);
                     end
            default: ;
        endcase
    end

    // Control FSM with registered handshake and chip-select outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_WAKE;
            ready    <= 1'b0;
            ack      <= 1'b0;
            dout     <= '0;
            spi_cs_n <= 1'b1;
            wcnt     <= '0;
            baddr    <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_WAKE: begin
                    if (spi_cs_n) begin
                        spi_cs_n <= 1'b0;
                    end else if (sh_last) begin
                        spi_cs_n <= 1'b1;
                        wcnt     <= 16'(WAKE_WAIT + 1);
                        state    <= S_WGAP;
                    end
                end
                S_WGAP, S_GAP: begin
                    if (wcnt == 16'd0) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wcnt <= wcnt - 16'd1;
                    end
                end
                S_IDLE: begin
                    if (rd) begin
                        ready    <= 1'b0;
                        spi_cs_n <= 1'b0;
                        baddr    <= {1'b0, addr, 1'b0};
                        state    <= S_CMD;
                    end
                end
                S_CMD:   if (sh_last) state <= S_ADDR;
                S_ADDR:  if (sh_last) state <= (DUMMY_BITS > 0) ? S_DUMMY : S_DATA;
                S_DUMMY: if (sh_last) state <= S_DATA;
                S_DATA: begin
                    if (sh_last) begin
                        dout     <= sh_rx;
                        ack      <= 1'b1;
                        spi_cs_n <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    wcnt  <= 16'd1;
                    state <= S_GAP;
                end
                default: state <= S_WAKE;
            endcase
        end
    end

endmodule
